// File: rtl/ula_pkg.sv
// Shared definitions for the ULA datapath and its command sequencer.
package ula_pkg;

  // ULA function codes
  localparam logic [2:0] FUNC_LOADA = 3'd0;
  localparam logic [2:0] FUNC_ADD   = 3'd1;
  localparam logic [2:0] FUNC_SUB   = 3'd2;
  localparam logic [2:0] FUNC_AND   = 3'd3;
  localparam logic [2:0] FUNC_PLUS1 = 3'd4;
  localparam logic [2:0] FUNC_NOT   = 3'd5;
  localparam logic [2:0] FUNC_XOR   = 3'd6;
  localparam logic [2:0] FUNC_COMP  = 3'd7;

  // Sequencer macro-operations; encodings 11..15 are illegal
  typedef enum logic [3:0] {
    OpPass = 4'd0,
    OpAdd  = 4'd1,
    OpSub  = 4'd2,
    OpAnd  = 4'd3,
    OpInc  = 4'd4,
    OpNot  = 4'd5,
    OpXor  = 4'd6,
    OpCmp  = 4'd7,
    OpNeg  = 4'd8,
    OpMul  = 4'd9,
    OpMax  = 4'd10
  } macro_op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StExec    = 3'd1,
    StStep2   = 3'd2,
    StMulLoop = 3'd3,
    StDone    = 3'd4
  } seq_state_e;

  function automatic logic op_legal(logic [3:0] op);
    return op <= 4'd10;
  endfunction

  // ULA function used for the first (EXEC) pass of a macro-op
  function automatic logic [2:0] exec_func(macro_op_e op);
    logic [2:0] f;
    case (op)
      OpAdd:         f = FUNC_ADD;
      OpSub:         f = FUNC_SUB;
      OpAnd:         f = FUNC_AND;
      OpInc:         f = FUNC_PLUS1;
      OpNot, OpNeg:  f = FUNC_NOT;
      OpXor:         f = FUNC_XOR;
      OpCmp, OpMax:  f = FUNC_COMP;
      default:       f = FUNC_LOADA;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ula_seq.sv
// Command sequencer for the ULA: runs single- and multi-pass macro-ops and
// returns a registered result word plus qualified flags.
module ula_seq
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [3:0]  cmdOp,
  input  logic [31:0] cmdA,
  input  logic [31:0] cmdB,
  output logic        resValid,
  input  logic        resReady,
  output logic [31:0] resData,
  output logic        resZ,
  output logic        resN,
  output logic        resO,
  output logic        resET,
  output logic        resGT,
  output logic        resLT,
  output logic        resErr,
  output logic [31:0] ulaA,
  output logic [31:0] ulaB,
  output logic [2:0]  func,
  input  logic [31:0] ulaOutput,
  input  logic        ulaZ,
  input  logic        ulaN,
  input  logic        ulaO,
  input  logic        ulaET,
  input  logic        ulaGT,
  input  logic        ulaLT
);

  seq_state_e  state_q, state_d;
  macro_op_e   op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ula_a_q, ula_a_d, ula_b_q, ula_b_d;
  logic [2:0]  func_q, func_d;
  logic [31:0] data_q, data_d;
  logic        z_q, z_d, n_q, n_d, o_q, o_d;
  logic        et_q, et_d, gt_q, gt_d, lt_q, lt_d;
  logic        err_q, err_d;
  logic        finish;

  // Z/N are derived from the captured result word, not the ULA flags
  logic unused_ula_flags;
  assign unused_ula_flags = ulaZ ^ ulaN;

  // Next-state, ULA drive and result capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ula_a_d = ula_a_q;
    ula_b_d = ula_b_q;
    func_d  = func_q;
    data_d  = data_q;
    z_d     = z_q;
    n_d     = n_q;
    o_d     = o_q;
    et_d    = et_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    err_d   = err_q;
    finish  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmdValid) begin
          data_d = '0;
          z_d    = 1'b0;
          n_d    = 1'b0;
          o_d    = 1'b0;
          et_d   = 1'b0;
          gt_d   = 1'b0;
          lt_d   = 1'b0;
          err_d  = 1'b0;
          if (!op_legal(cmdOp)) begin
            // An error result carries no flags, only resErr
            err_d  = 1'b1;
            finish = 1'b1;
          end else begin
            op_d = macro_op_e'(cmdOp);
            if (cmdOp == OpMul) begin
              if (cmdB[7:0] == 8'd0) begin
                z_d    = 1'b1;
                finish = 1'b1;
              end else begin
                // ulaA carries the running accumulator, ulaB the multiplicand
                cnt_d   = cmdB[7:0];
                ula_a_d = '0;
                ula_b_d = cmdA;
                func_d  = FUNC_ADD;
                state_d = StMulLoop;
              end
            end else begin
              ula_a_d = cmdA;
              ula_b_d = cmdB;
              func_d  = exec_func(macro_op_e'(cmdOp));
              state_d = StExec;
            end
          end
        end
      end

      StExec: begin
        unique case (op_q)
          OpNeg: begin
            ula_a_d = ulaOutput;
            ula_b_d = '0;
            func_d  = FUNC_PLUS1;
            state_d = StStep2;
          end
          OpMax: begin
            et_d    = ulaET;
            gt_d    = ulaGT;
            lt_d    = ulaLT;
            ula_a_d = ulaLT ? ula_b_q : ula_a_q;
            ula_b_d = '0;
            func_d  = FUNC_LOADA;
            state_d = StStep2;
          end
          OpCmp: begin
            // ULA output is stale under COMP: report only the relation
            et_d   = ulaET;
            gt_d   = ulaGT;
            lt_d   = ulaLT;
            finish = 1'b1;
          end
          default: begin
            data_d = ulaOutput;
            z_d    = (ulaOutput == '0);
            n_d    = ulaOutput[31];
            o_d    = ((op_q == OpAdd) || (op_q == OpSub)) ? ulaO : 1'b0;
            finish = 1'b1;
          end
        endcase
      end

      StStep2: begin
        data_d = ulaOutput;
        z_d    = (ulaOutput == '0);
        n_d    = ulaOutput[31];
        finish = 1'b1;
      end

      StMulLoop: begin
        o_d   = o_q | ulaO;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          data_d = ulaOutput;
          z_d    = (ulaOutput == '0);
          n_d    = ulaOutput[31];
          finish = 1'b1;
        end else begin
          ula_a_d = ulaOutput;
        end
      end

      StDone: begin
        if (resReady) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Result complete: park the ULA and present it
    if (finish) begin
      state_d = StDone;
      ula_a_d = '0;
      ula_b_d = '0;
      func_d  = FUNC_LOADA;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpPass;
      cnt_q   <= '0;
      ula_a_q <= '0;
      ula_b_q <= '0;
      func_q  <= FUNC_LOADA;
      data_q  <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      o_q     <= 1'b0;
      et_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ula_a_q <= ula_a_d;
      ula_b_q <= ula_b_d;
      func_q  <= func_d;
      data_q  <= data_d;
      z_q     <= z_d;
      n_q     <= n_d;
      o_q     <= o_d;
      et_q    <= et_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
    end
  end

  assign cmdReady = (state_q == StIdle) && !reset;
  assign resValid = (state_q == StDone);
  assign resData  = data_q;
  assign resZ     = z_q;
  assign resN     = n_q;
  assign resO     = o_q;
  assign resET    = et_q;
  assign resGT    = gt_q;
  assign resLT    = lt_q;
  assign resErr   = err_q;
  assign ulaA     = ula_a_q;
  assign ulaB     = ula_b_q;
  assign func     = func_q;

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: behavioural ULA, arithmetic result model, directed and
// random commands with random result backpressure.
module tb_ula_seq;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [3:0]  cmdOp = '0;
  logic [31:0] cmdA = '0, cmdB = '0;
  logic        resValid;
  logic        resReady = 1'b0;
  logic [31:0] resData;
  logic        resZ, resN, resO, resET, resGT, resLT, resErr;
  logic [31:0] ulaA, ulaB;
  logic [2:0]  func;
  logic [31:0] ulaOutput;
  logic        ulaZ, ulaN, ulaO, ulaET, ulaGT, ulaLT;

  ula_seq dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB),
    .resValid(resValid), .resReady(resReady), .resData(resData),
    .resZ(resZ), .resN(resN), .resO(resO), .resET(resET), .resGT(resGT), .resLT(resLT),
    .resErr(resErr), .ulaA(ulaA), .ulaB(ulaB), .func(func),
    .ulaOutput(ulaOutput), .ulaZ(ulaZ), .ulaN(ulaN), .ulaO(ulaO),
    .ulaET(ulaET), .ulaGT(ulaGT), .ulaLT(ulaLT)
  );

  always #5 clk = ~clk;

  // Combinational ULA; output is garbage under COMP, relations always driven
  always_comb begin
    ulaOutput = 32'hDEAD_BEEF;
    ulaO      = 1'b0;
    case (func)
      FUNC_LOADA: ulaOutput = ulaA;
      FUNC_ADD: begin
        ulaOutput = ulaA + ulaB;
        ulaO = (ulaA[31] == ulaB[31]) && (ulaOutput[31] != ulaA[31]);
      end
      FUNC_SUB: begin
        ulaOutput = ulaA - ulaB;
        ulaO = (ulaA[31] != ulaB[31]) && (ulaOutput[31] != ulaA[31]);
      end
      FUNC_AND:   ulaOutput = ulaA & ulaB;
      FUNC_PLUS1: ulaOutput = ulaA + 32'd1;
      FUNC_NOT:   ulaOutput = ~ulaA;
      FUNC_XOR:   ulaOutput = ulaA ^ ulaB;
      default:    ulaOutput = 32'hDEAD_BEEF;
    endcase
    ulaZ  = (ulaOutput == 32'd0);
    ulaN  = ulaOutput[31];
    ulaET = (ulaA == ulaB);
    ulaGT = (ulaA > ulaB);
    ulaLT = (ulaA < ulaB);
  end

  typedef struct {
    logic [31:0] d;
    logic z, n, o, et, gt, lt, err;
    int lat;
    int nadd;
  } res_t;

  localparam longint MaxS = 2147483647;
  localparam longint MinS = -MaxS - 1;

  function automatic logic ovf(longint s);
    return (s > MaxS) || (s < MinS);
  endfunction

  // Expected outcome and latency of one macro-op
  function automatic res_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    res_t r;
    longint s;
    logic [31:0] acc;
    int cnt;
    r.d = 0; r.z = 0; r.n = 0; r.o = 0; r.et = 0; r.gt = 0; r.lt = 0; r.err = 0;
    r.lat = 2; r.nadd = 0;
    case (op)
      4'd0: r.d = a;
      4'd1: begin
        r.d = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        r.o = ovf(s);
      end
      4'd2: begin
        r.d = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        r.o = ovf(s);
      end
      4'd3: r.d = a & b;
      4'd4: r.d = a + 1;
      4'd5: r.d = ~a;
      4'd6: r.d = a ^ b;
      4'd7: begin
        r.et = (a == b); r.gt = (a > b); r.lt = (a < b);
      end
      4'd8: begin
        r.d = 32'd0 - a; r.lat = 3;
      end
      4'd9: begin
        cnt = int'(b[7:0]);
        acc = 0;
        for (int k = 0; k < cnt; k++) begin
          s = longint'($signed(acc)) + longint'($signed(a));
          if (ovf(s)) r.o = 1;
          acc = acc + a;
        end
        r.d = acc;
        r.nadd = cnt;
        r.lat = (cnt == 0) ? 1 : cnt + 1;
      end
      4'd10: begin
        r.et = (a == b); r.gt = (a > b); r.lt = (a < b);
        r.d = (a < b) ? b : a;
        r.lat = 3;
      end
      default: begin
        r.err = 1; r.lat = 1;
      end
    endcase
    if (op <= 4'd10 && op != 4'd7) begin
      r.z = (r.d == 0);
      r.n = r.d[31];
    end
    return r;
  endfunction

  int   checks = 0;
  int   fails = 0;
  res_t exp_r;
  bit   exp_mul = 0;
  bit   pending = 0;
  bit   seen = 0;
  int   cycles = 0;
  int   add_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!reset) begin
      if (pending) cycles++;
      if (resValid) begin
        if (!pending) begin
          check("unexpected resValid", 32'(resValid), 32'd0);
        end else begin
          if (!seen) begin
            check("result latency", cycles, exp_r.lat);
            if (exp_mul) check("mul add passes", add_cnt, exp_r.nadd);
            seen = 1;
          end
          check("resData", resData, exp_r.d);
          check("resZ", 32'(resZ), 32'(exp_r.z));
          check("resN", 32'(resN), 32'(exp_r.n));
          check("resO", 32'(resO), 32'(exp_r.o));
          check("resET", 32'(resET), 32'(exp_r.et));
          check("resGT", 32'(resGT), 32'(exp_r.gt));
          check("resLT", 32'(resLT), 32'(exp_r.lt));
          check("resErr", 32'(resErr), 32'(exp_r.err));
          check("cmdReady while done", 32'(cmdReady), 32'd0);
        end
      end else if (pending) begin
        check("cmdReady while busy", 32'(cmdReady), 32'd0);
        if (func == FUNC_ADD) add_cnt++;
      end else begin
        check("cmdReady idle", 32'(cmdReady), 32'd1);
        check("ulaA idle", ulaA, 32'd0);
        check("ulaB idle", ulaB, 32'd0);
        check("func idle", 32'(func), 32'(FUNC_LOADA));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pending = 0;
    #1;
    check("reset resValid", 32'(resValid), 32'd0);
    check("reset resData", resData, 32'd0);
    check("reset flags", {25'd0, resZ, resN, resO, resET, resGT, resLT, resErr}, 32'd0);
    check("reset ulaA", ulaA, 32'd0);
    check("reset ulaB", ulaB, 32'd0);
    check("reset func", 32'(func), 32'(FUNC_LOADA));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present a command at a negedge; returns once it has been accepted
  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b, bit rr);
    int guard = 0;
    @(negedge clk);
    while (!cmdReady && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("cmdReady wait", 32'(cmdReady), 32'd1);
    cmdValid = 1'b1; cmdOp = op; cmdA = a; cmdB = b;
    resReady = rr;
    exp_r = model(op, a, b);
    exp_mul = (op == 4'd9);
    seen = 0; add_cnt = 0;
    @(posedge clk);
    pending = 1; cycles = 0;
    #1 cmdValid = 1'b0;
    cmdA = $urandom; cmdB = $urandom;
  endtask

  task automatic run(logic [3:0] op, logic [31:0] a, logic [31:0] b, int stall);
    int guard = 0;
    send(op, a, b, stall == 0);
    @(negedge clk);
    while (!resValid && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    if (!resValid) begin
      check("resValid timeout", 32'd0, 32'd1);
      do_reset();
      return;
    end
    repeat (stall) @(negedge clk);
    resReady = 1'b1;
    @(posedge clk);
    pending = 0;
    #1 resReady = 1'b0;
  endtask

  res_t m;

  initial begin
    // Model pinned against hand-computed values
    m = model(4'd1, 32'd5, 32'd7);
    check("model add", m.d, 32'd12);
    m = model(4'd2, 32'h8000_0000, 32'd1);
    check("model sub", {m.d[30:0], m.o}, {31'h7FFF_FFFF, 1'b1});
    m = model(4'd8, 32'd5, 32'd0);
    check("model neg", m.d, 32'hFFFF_FFFB);
    m = model(4'd10, 32'd3, 32'd9);
    check("model max", {m.d[27:0], m.et, m.gt, m.lt, m.n}, {28'd9, 4'b0010});
    m = model(4'd9, 32'd6, 32'd7);
    check("model mul", m.d, 32'd42);
    m = model(4'd9, 32'h4000_0000, 32'd4);
    check("model mul ovf", {m.d[30:0], m.o}, {31'd0, 1'b1});
    m = model(4'd9, 32'd9, 32'h100);
    check("model mul zero", {m.d[29:0], m.z, m.lat[0]}, {30'd0, 1'b1, 1'b1});

    do_reset();

    run(4'd1, 32'd5, 32'd7, 0);
    run(4'd2, 32'h8000_0000, 32'd1, 0);
    run(4'd8, 32'd5, 32'd0, 0);
    run(4'd10, 32'd3, 32'd9, 0);
    run(4'd9, 32'd6, 32'd7, 0);
    run(4'd9, 32'd3, 32'h100, 0);
    run(4'd9, 32'h4000_0000, 32'd4, 0);
    run(4'd12, 32'd1, 32'd2, 0);
    run(4'd7, 32'h55, 32'h55, 5);

    // Reset in the third MULLOOP cycle of 6 x 7
    send(4'd9, 32'd6, 32'd7, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    pending = 0;
    #1;
    check("midreset resValid", 32'(resValid), 32'd0);
    check("midreset resData", resData, 32'd0);
    check("midreset flags", {25'd0, resZ, resN, resO, resET, resGT, resLT, resErr}, 32'd0);
    check("midreset ulaA", ulaA, 32'd0);
    check("midreset ulaB", ulaB, 32'd0);
    check("midreset func", 32'(func), 32'(FUNC_LOADA));
    @(negedge clk);
    reset = 1'b0;
    resReady = 1'b0;
    run(4'd1, 32'd1, 32'd1, 0);

    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) b = a;
      if (op == 4'd9) b[7:0] = 8'($urandom_range(0, 12));
      run(op, a, b, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
